// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 4-bit write-only LCD controller:
// default timing constants (in clock ticks), controller state encoding,
// HD44780 command bytes used by the power-on init, and small helpers.
package hd44780_pkg;

  localparam int unsigned T_POWERUP_DEF  = 1_200_000;
  localparam int unsigned T_4P1MS_DEF    = 49_200;
  localparam int unsigned T_100US_DEF    = 1_200;
  localparam int unsigned T_3MS_DEF      = 36_000;
  localparam int unsigned T_53US_DEF     = 636;
  localparam int unsigned TAS_DEF        = 1;
  localparam int unsigned PWEH_DEF       = 6;
  localparam int unsigned TAH_DEF        = 1;
  localparam int unsigned E_PAD_DEF      = 7;
  localparam int unsigned BLINK_BITS_DEF = 22;

  localparam logic [7:0] FUNC_SET_4BIT_2L = 8'h28;
  localparam logic [7:0] DISP_OFF         = 8'h08;
  localparam logic [7:0] CLEAR            = 8'h01;
  localparam logic [7:0] ENTRY_INC        = 8'h06;
  localparam logic [7:0] DISP_ON          = 8'h0C;

  localparam int unsigned N_INIT_BYTES = 5;

  typedef enum logic [3:0] {
    ST_RESET_WAIT,
    ST_INIT3A,
    ST_INIT3B,
    ST_INIT3C,
    ST_INIT2,
    ST_IDLE,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_POST_WAIT
  } state_t;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Byte sent at position idx of the full-byte part of the init sequence.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return FUNC_SET_4BIT_2L;
      3'd1:    return DISP_OFF;
      3'd2:    return CLEAR;
      3'd3:    return ENTRY_INC;
      default: return DISP_ON;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long post-command wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == 8'h01) || (b == 8'h02) || (b == 8'h03));
  endfunction

endpackage

// File: rtl/hd44780_lcd_ctrl_if.sv
// User-side byte handshake of the LCD controller.
//   STB_I      : one-cycle request strobe (master -> slave)
//   i_rs       : register select, 0 = command, 1 = data
//   i_lcd_data : byte to send
//   busy       : controller cannot accept STB_I (slave -> master)
interface hd44780_lcd_ctrl_if;
  logic       STB_I;
  logic       i_rs;
  logic [7:0] i_lcd_data;
  logic       busy;

  modport master (output STB_I, output i_rs, output i_lcd_data, input busy);
  modport slave  (input STB_I, input i_rs, input i_lcd_data, output busy);
endinterface

// File: rtl/hd44780_nybble_sender.sv
// Sends one nybble to the LCD bus with HD44780 E-pulse timing.
// A cycle lasts TAS+PWEH+TAH+E_PAD ticks from the launch tick: rs/data are
// registered at launch and held, E is low for TAS ticks, high for PWEH
// ticks, then low for the remainder.
//   clk, rst_n : clock, async active-low reset
//   start      : launch a cycle (honoured when busy = 0)
//   rs, nybble : values to present on the bus
//   o_rs, o_lcd_data, o_e : LCD pins (all registered)
//   busy       : a cycle is in progress and is not on its final tick
//   done       : final tick of the cycle; a new start may be issued here
module hd44780_nybble_sender
  import hd44780_pkg::*;
#(
  parameter int unsigned TAS   = TAS_DEF,
  parameter int unsigned PWEH  = PWEH_DEF,
  parameter int unsigned TAH   = TAH_DEF,
  parameter int unsigned E_PAD = E_PAD_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nybble,
  output logic       o_rs,
  output logic [3:0] o_lcd_data,
  output logic       o_e,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CYCLE = TAS + PWEH + TAH + E_PAD;
  localparam int unsigned CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [3:0]    data_q, data_d;
  logic          e_q, e_d;

  assign done = active_q && (cnt_q == CW'(CYCLE - 1));
  assign busy = active_q && !done;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    data_d   = data_q;
    if (start && !busy) begin
      active_d = 1'b1;
      cnt_d    = '0;
      rs_d     = rs;
      data_d   = nybble;
    end else if (done) begin
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + CW'(1);
    end
    // E is registered from the next count so the pin itself is glitch-free.
    e_d = active_d && (cnt_d >= CW'(TAS)) && (cnt_d < CW'(TAS + PWEH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      data_q   <= '0;
      e_q      <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
      e_q      <= e_d;
    end
  end

  assign o_rs       = rs_q;
  assign o_lcd_data = data_q;
  assign o_e        = e_q;

endmodule

// File: rtl/hd44780_lcd_ctrl.sv
// HD44780 character LCD controller, 4-bit write-only mode.
// Runs the 4-bit power-on init after reset, then sends user bytes as two
// nybbles (high first) followed by the command-dependent wait.
//   CLK_I     : system clock
//   RST_I     : async active-low reset
//   bus       : byte handshake (STB_I, i_rs, i_lcd_data in; busy out)
//   alive_led : heartbeat, MSB of a free-running counter
//   o_rs, o_lcd_data, o_e : LCD RS, DB7..DB4 and E pins
module hd44780_lcd_ctrl
  import hd44780_pkg::*;
#(
  parameter int unsigned T_POWERUP  = T_POWERUP_DEF,
  parameter int unsigned T_4P1MS    = T_4P1MS_DEF,
  parameter int unsigned T_100US    = T_100US_DEF,
  parameter int unsigned T_3MS      = T_3MS_DEF,
  parameter int unsigned T_53US     = T_53US_DEF,
  parameter int unsigned TAS        = TAS_DEF,
  parameter int unsigned PWEH       = PWEH_DEF,
  parameter int unsigned TAH        = TAH_DEF,
  parameter int unsigned E_PAD      = E_PAD_DEF,
  parameter int unsigned BLINK_BITS = BLINK_BITS_DEF,
  parameter int unsigned SKIP_INIT  = 0
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  hd44780_lcd_ctrl_if.slave   bus,
  output logic                alive_led,
  output logic                o_rs,
  output logic [3:0]          o_lcd_data,
  output logic                o_e
);

  localparam int unsigned T_MAX =
    umax(umax(T_POWERUP, T_4P1MS), umax(umax(T_100US, T_3MS), T_53US));
  localparam int unsigned TW = $clog2(T_MAX + 1);

  state_t          state_q, state_d;
  state_t          ret_q, ret_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [7:0]      byte_q, byte_d;
  logic            rs_q, rs_d;
  logic [2:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;

  logic            tmr_last;
  logic            snd_start, snd_rs, snd_busy, snd_done;
  logic [3:0]      snd_nyb;

  // A wait of N ticks ends on the tick the counter shows 1 (or 0 for N = 0).
  assign tmr_last = (tmr_q <= TW'(1));

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    idx_d   = idx_q;
    tmr_d   = (tmr_q != '0) ? tmr_q - TW'(1) : '0;

    case (state_q)
      ST_RESET_WAIT: if (tmr_last) state_d = ST_INIT3A;
      ST_INIT3A: if (snd_done) begin
        tmr_d = TW'(T_4P1MS); ret_d = ST_INIT3B; state_d = ST_POST_WAIT;
      end
      ST_INIT3B: if (snd_done) begin
        tmr_d = TW'(T_100US); ret_d = ST_INIT3C; state_d = ST_POST_WAIT;
      end
      ST_INIT3C: if (snd_done) begin
        tmr_d = TW'(T_100US); ret_d = ST_INIT2; state_d = ST_POST_WAIT;
      end
      ST_INIT2: if (snd_done) begin
        tmr_d   = TW'(T_53US);
        ret_d   = ST_SEND_HI;
        idx_d   = '0;
        byte_d  = init_byte('0);
        rs_d    = 1'b0;
        state_d = ST_POST_WAIT;
      end
      ST_IDLE: if (bus.STB_I && !busy_q && !snd_busy) begin
        byte_d  = bus.i_lcd_data;
        rs_d    = bus.i_rs;
        state_d = ST_SEND_HI;
      end
      ST_SEND_HI: if (snd_done) state_d = ST_SEND_LO;
      ST_SEND_LO: if (snd_done) begin
        tmr_d   = is_long_cmd(rs_q, byte_q) ? TW'(T_3MS) : TW'(T_53US);
        state_d = ST_POST_WAIT;
        // Init bytes reuse the user send path; idx_q == N_INIT_BYTES marks
        // that init is over and every later byte returns to IDLE.
        if (idx_q < 3'(N_INIT_BYTES - 1)) begin
          idx_d  = idx_q + 3'd1;
          byte_d = init_byte(idx_q + 3'd1);
          ret_d  = ST_SEND_HI;
        end else begin
          idx_d = 3'(N_INIT_BYTES);
          ret_d = ST_IDLE;
        end
      end
      ST_POST_WAIT: if (tmr_last) state_d = ret_q;
      default: state_d = ST_IDLE;
    endcase

    // Nybbles are launched on entry to a sending state, so the launch tick
    // coincides with the state change (including SEND_HI -> SEND_LO on done).
    snd_start = 1'b0;
    snd_rs    = 1'b0;
    snd_nyb   = '0;
    if (state_d != state_q) begin
      case (state_d)
        ST_INIT3A, ST_INIT3B, ST_INIT3C: begin snd_start = 1'b1; snd_nyb = 4'h3; end
        ST_INIT2:   begin snd_start = 1'b1; snd_nyb = 4'h2; end
        ST_SEND_HI: begin snd_start = 1'b1; snd_rs = rs_d; snd_nyb = byte_d[7:4]; end
        ST_SEND_LO: begin snd_start = 1'b1; snd_rs = rs_d; snd_nyb = byte_d[3:0]; end
        default: ;
      endcase
    end

    busy_d  = (state_d != ST_IDLE);
    blink_d = blink_q + BLINK_BITS'(1);
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= (SKIP_INIT != 0) ? ST_IDLE : ST_RESET_WAIT;
      tmr_q   <= (SKIP_INIT != 0) ? '0 : TW'(T_POWERUP);
      ret_q   <= ST_IDLE;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      idx_q   <= 3'(N_INIT_BYTES);
      busy_q  <= 1'b1;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ret_q   <= ret_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      blink_q <= blink_d;
    end
  end

  hd44780_nybble_sender #(
    .TAS   (TAS),
    .PWEH  (PWEH),
    .TAH   (TAH),
    .E_PAD (E_PAD)
  ) u_sender (
    .clk        (CLK_I),
    .rst_n      (RST_I),
    .start      (snd_start),
    .rs         (snd_rs),
    .nybble     (snd_nyb),
    .o_rs       (o_rs),
    .o_lcd_data (o_lcd_data),
    .o_e        (o_e),
    .busy       (snd_busy),
    .done       (snd_done)
  );

  assign bus.busy  = busy_q;
  assign alive_led = blink_q[BLINK_BITS-1];

endmodule

// File: tb/tb_hd44780_lcd_ctrl.sv
// Bench for hd44780_lcd_ctrl. dut_a skips init (short delays, small blink
// counter); dut_b runs the full init with shortened delays. Expected
// {rs, nybble} pairs are queued when stimulus is driven and compared when
// each E pulse rises.
module tb_hd44780_lcd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;
  logic led_a, rs_a, e_a, led_b, rs_b, e_b;
  logic [3:0] d_a, d_b;

  hd44780_lcd_ctrl_if bus_a ();
  hd44780_lcd_ctrl_if bus_b ();

  hd44780_lcd_ctrl #(
    .T_53US(5), .T_3MS(40), .BLINK_BITS(4), .SKIP_INIT(1)
  ) dut_a (
    .CLK_I(clk), .RST_I(rst_a_n), .bus(bus_a), .alive_led(led_a),
    .o_rs(rs_a), .o_lcd_data(d_a), .o_e(e_a)
  );

  hd44780_lcd_ctrl #(
    .T_POWERUP(50), .T_4P1MS(5), .T_100US(5), .T_3MS(5), .T_53US(5),
    .SKIP_INIT(0)
  ) dut_b (
    .CLK_I(clk), .RST_I(rst_b_n), .bus(bus_b), .alive_led(led_b),
    .o_rs(rs_b), .o_lcd_data(d_b), .o_e(e_b)
  );

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_a[$];
  logic [4:0] exp_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- E-pulse monitors / scoreboards ----------------
  logic e_a_prev = 1'b0, e_b_prev = 1'b0;
  int   w_a = 0, w_b = 0;

  always @(negedge clk) begin
    if (!rst_a_n) begin
      e_a_prev = 1'b0; w_a = 0;
    end else begin
      if (e_a && !e_a_prev) begin
        check("a_unexpected_nybble", exp_a.size() != 0, 1);
        if (exp_a.size() != 0) check("a_nybble", {rs_a, d_a}, exp_a.pop_front());
        w_a = 1;
      end else if (e_a) begin
        w_a++;
      end else if (e_a_prev) begin
        check("a_e_width", w_a, 6);
      end
      e_a_prev = e_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_b_n) begin
      e_b_prev = 1'b0; w_b = 0;
    end else begin
      if (e_b && !e_b_prev) begin
        check("b_busy_during_init", bus_b.busy, 1);
        check("b_unexpected_nybble", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) check("b_nybble", {rs_b, d_b}, exp_b.pop_front());
        w_b = 1;
      end else if (e_b) begin
        w_b++;
      end else if (e_b_prev) begin
        check("b_e_width", w_b, 6);
      end
      e_b_prev = e_b;
    end
  end

  // Waits for idle, strobes one byte, returns how many ticks busy stayed high.
  task automatic send_byte(input logic rs, input logic [7:0] b, output int busy_ticks);
    int n;
    n = 0;
    while (bus_a.busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    check("a_idle_timeout", n < 500, 1);
    bus_a.i_rs = rs; bus_a.i_lcd_data = b; bus_a.STB_I = 1'b1;
    exp_a.push_back({rs, b[7:4]});
    exp_a.push_back({rs, b[3:0]});
    @(negedge clk);
    bus_a.STB_I = 1'b0;
    busy_ticks = 0;
    while (bus_a.busy === 1'b1 && busy_ticks < 500) begin
      busy_ticks++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] init_nyb [14];
    int n, t;
    logic exp_busy, exp_e;
    logic [3:0] exp_d;

    init_nyb = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h8,
                 4'h0, 4'h1, 4'h0, 4'h6, 4'h0, 4'hC};
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    bus_a.STB_I = 1'b0; bus_a.i_rs = 1'b0; bus_a.i_lcd_data = '0;
    bus_b.STB_I = 1'b0; bus_b.i_rs = 1'b0; bus_b.i_lcd_data = '0;
    for (int i = 0; i < 14; i++) exp_b.push_back({1'b0, init_nyb[i]});

    // Reset state
    @(negedge clk);
    check("rst_o_e", e_a, 0);
    check("rst_o_rs", rs_a, 0);
    check("rst_o_lcd_data", d_a, 0);
    check("rst_alive_led", led_a, 0);
    check("rst_busy_a", bus_a.busy, 1);
    check("rst_busy_b", bus_b.busy, 1);
    #2 rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Full init: 50 power-up + 4 x (15+5) + 5 x (30+5) = 305 ticks busy
    n = 0;
    do begin @(negedge clk); n++; end while (bus_b.busy !== 1'b0 && n < 1000);
    check("b_init_busy_ticks", n, 305);
    check("b_init_all_nybbles_seen", exp_b.size(), 0);
    check("b_rs_after_init", rs_b, 0);

    // Data byte 0x6D, with ignored strobes during the send and POST_WAIT
    check("a_idle_before_send", bus_a.busy, 0);
    bus_a.i_rs = 1'b1; bus_a.i_lcd_data = 8'h6D; bus_a.STB_I = 1'b1;
    exp_a.push_back({1'b1, 4'h6});
    exp_a.push_back({1'b1, 4'hD});
    @(negedge clk);
    bus_a.STB_I = 1'b0;
    for (int k = 0; k < 40; k++) begin
      exp_busy = (k <= 34);
      exp_e    = (k >= 1 && k <= 6) || (k >= 16 && k <= 21);
      exp_d    = (k <= 14) ? 4'h6 : 4'hD;
      check($sformatf("s2_busy_k%0d", k), bus_a.busy, exp_busy);
      check($sformatf("s2_e_k%0d", k), e_a, exp_e);
      check($sformatf("s2_data_k%0d", k), d_a, exp_d);
      check($sformatf("s2_rs_k%0d", k), rs_a, 1);
      if (k == 4) begin
        bus_a.STB_I = 1'b1; bus_a.i_rs = 1'b0; bus_a.i_lcd_data = 8'h8E;
      end else if (k == 31) begin
        bus_a.STB_I = 1'b1; bus_a.i_rs = 1'b0; bus_a.i_lcd_data = 8'h5A;
      end else begin
        bus_a.STB_I = 1'b0;
      end
      @(negedge clk);
    end

    // Accepted strobe once idle again
    send_byte(1'b0, 8'hCB, t);
    check("cb_busy_ticks", t, 35);

    // Long and short post-command waits (T_3MS = 40, T_53US = 5)
    send_byte(1'b0, 8'h01, t);
    check("clear_busy_ticks", t, 70);
    send_byte(1'b0, 8'h03, t);
    check("home3_busy_ticks", t, 70);
    send_byte(1'b1, 8'h01, t);
    check("data01_busy_ticks", t, 35);
    send_byte(1'b0, 8'h04, t);
    check("cmd04_busy_ticks", t, 35);

    // Reset while E is high
    bus_a.i_rs = 1'b1; bus_a.i_lcd_data = 8'h6D; bus_a.STB_I = 1'b1;
    exp_a.push_back({1'b1, 4'h6});
    exp_a.push_back({1'b1, 4'hD});
    @(negedge clk);
    bus_a.STB_I = 1'b0;
    n = 0;
    while (e_a !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("e_high_timeout", n < 50, 1);
    #2 rst_a_n = 1'b0;
    #1;
    check("midrst_o_e", e_a, 0);
    check("midrst_o_rs", rs_a, 0);
    check("midrst_o_lcd_data", d_a, 0);
    check("midrst_busy", bus_a.busy, 1);
    check("midrst_alive_led", led_a, 0);
    exp_a.delete();
    @(negedge clk);
    #2 rst_a_n = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      check($sformatf("alive_led_j%0d", j), led_a, (j >> 3) & 1);
      if (j == 1) check("post_rst_idle", bus_a.busy, 0);
    end
    send_byte(1'b0, 8'hA5, t);
    check("post_rst_send_busy_ticks", t, 35);

    check("a_scoreboard_empty", exp_a.size(), 0);
    check("b_scoreboard_empty", exp_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
